// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Turns one raw, bouncing pushbutton pin into clean, clock-aligned events.
// The pin is brought into the clock domain by a two-flop synchroniser and
// then passed through a four-state debounce FSM. A level change is accepted
// only after the synchronised input has held its new value for
// DEBOUNCE_CYCLES clocks. Accepted changes produce single-cycle press and
// release strobes. A hold timer produces a long-press strobe, and a 5-bit
// counter tallies short presses so it can drive a 5-LED display directly.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles needed before a change is accepted (>= 2)
//   LONG_CYCLES      accepted-pressed cycles before BTN_LONG fires (>= 1)
//   ACTIVE_LOW       1: the pin reads 0 when pressed; 0: it reads 1 when pressed
//
// Ports
//   CLK_IN       in   system clock; all state updates on its rising edge
//   RST_IN       in   asynchronous, active-high reset
//   BTN_IN       in   raw pushbutton pin, asynchronous to CLK_IN
//   BTN_LEVEL    out  debounced state, 1 = pressed
//   BTN_PRESS    out  one-cycle strobe on an accepted press
//   BTN_RELEASE  out  one-cycle strobe on an accepted release
//   BTN_LONG     out  one-cycle strobe, at most once per press
//   PRESS_COUNT  out  accepted short presses, modulo 32
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       CLK_IN,
    input  logic       RST_IN,
    input  logic       BTN_IN,
    output logic       BTN_LEVEL,
    output logic       BTN_PRESS,
    output logic       BTN_RELEASE,
    output logic       BTN_LONG,
    output logic [4:0] PRESS_COUNT
);

    // Counter widths. Each counter only has to reach (parameter - 1), so
    // $clog2 of the parameter is enough; the guard keeps the width at least
    // one bit when a parameter is small enough to make $clog2 return 0.
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    // Debounce FSM encoding.
    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PEND_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_PEND_RELEASE = 2'd3;

    // Synchroniser flops. They reset to the pin's idle level so that reset
    // release never looks like a press.
    logic sync_a;
    logic sync_b;
    logic s;

    // Registered state and its next-state values.
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [DEB_W-1:0]  deb_cnt;
    logic [DEB_W-1:0]  deb_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic [HOLD_W-1:0] hold_sat;
    logic              fired;
    logic              fired_next;
    logic              level;
    logic              level_next;
    logic              press;
    logic              press_next;
    logic              release_q;
    logic              release_next;
    logic              long_q;
    logic              long_next;
    logic [4:0]        count;
    logic [4:0]        count_next;
    logic              holding;
    logic              releasing;

    // Two-flop synchroniser. The raw pin is asynchronous, so it only ever
    // reaches the FSM through these two flops.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            sync_a <= ACTIVE_LOW;
            sync_b <= ACTIVE_LOW;
        end else begin
            sync_a <= BTN_IN;
            sync_b <= sync_a;
        end
    end

    // Normalise the polarity so that s = 1 always means "pressed".
    assign s = sync_b ^ ACTIVE_LOW;

    // The hold timer runs while the button is accepted as pressed, which
    // includes a pending release, so a short bounce during a hold does not
    // restart the long-press timing. It saturates at its last value.
    assign holding   = (state == ST_PRESSED) || (state == ST_PEND_RELEASE);
    assign releasing = (state == ST_PEND_RELEASE) && !s && (deb_cnt == DEB_LAST);
    assign hold_sat  = (hold_cnt == HOLD_LAST) ? hold_cnt : (hold_cnt + HOLD_ONE);

    // Next-state logic for the debounce FSM, the hold timer, the strobes and
    // the press counter. Every output is registered, so each strobe below
    // becomes visible for exactly the one cycle after the accepting edge.
    always_comb begin
        state_next   = state;
        deb_next     = deb_cnt;
        hold_next    = hold_cnt;
        fired_next   = fired;
        level_next   = level;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        count_next   = count;

        case (state)
            ST_RELEASED: begin
                if (s) begin
                    state_next = ST_PEND_PRESS;
                    deb_next   = '0;
                end
            end

            ST_PEND_PRESS: begin
                if (!s) begin
                    state_next = ST_RELEASED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = ST_PRESSED;
                    level_next = 1'b1;
                    press_next = 1'b1;
                    hold_next  = '0;
                    fired_next = 1'b0;
                end else begin
                    deb_next = deb_cnt + DEB_ONE;
                end
            end

            ST_PRESSED: begin
                if (!s) begin
                    state_next = ST_PEND_RELEASE;
                    deb_next   = '0;
                end
            end

            ST_PEND_RELEASE: begin
                if (s) begin
                    state_next = ST_PRESSED;
                end else if (deb_cnt != DEB_LAST) begin
                    deb_next = deb_cnt + DEB_ONE;
                end
            end

            default: begin
                state_next = ST_RELEASED;
            end
        endcase

        // Hold timer and long-press strobe. The strobe is raised on the edge
        // where the timer reaches its last value. An accepted release on the
        // same edge takes precedence, so LONG and RELEASE can never coincide.
        if (holding && !releasing) begin
            hold_next = hold_sat;
            if ((hold_sat == HOLD_LAST) && !fired) begin
                long_next  = 1'b1;
                fired_next = 1'b1;
                count_next = '0;
            end
        end

        // Accepted release. Only a press that never became a long press is
        // counted; the counter wraps naturally from 31 to 0.
        if (releasing) begin
            state_next   = ST_RELEASED;
            level_next   = 1'b0;
            release_next = 1'b1;
            fired_next   = 1'b0;
            if (!fired) begin
                count_next = count + 5'd1;
            end
        end
    end

    // State registers. Reset clears everything immediately, including the
    // outputs, without waiting for a clock edge.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state     <= ST_RELEASED;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            fired     <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            count     <= '0;
        end else begin
            state     <= state_next;
            deb_cnt   <= deb_next;
            hold_cnt  <= hold_next;
            fired     <= fired_next;
            level     <= level_next;
            press     <= press_next;
            release_q <= release_next;
            long_q    <= long_next;
            count     <= count_next;
        end
    end

    assign BTN_LEVEL   = level;
    assign BTN_PRESS   = press;
    assign BTN_RELEASE = release_q;
    assign BTN_LONG    = long_q;
    assign PRESS_COUNT = count;

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=20
// and an active-low pin. Each scenario drives the pin for a number of clock
// edges, numbering the first edge after the scenario start as edge 0. Strobe
// occurrences and the edges on which they appear are tallied after every
// edge and then compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       level;
    logic       press;
    logic       release_s;
    logic       long_s;
    logic [4:0] count;

    int cmpCount;
    int errCount;

    int edgeIdx;
    int pressTally;
    int releaseTally;
    int longTally;
    int overlapTally;
    int firstLevelEdge;
    int pressEdge;
    int longEdge;
    int countAtLong;

    button_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .CLK_IN     (clk),
        .RST_IN     (rst),
        .BTN_IN     (btn),
        .BTN_LEVEL  (level),
        .BTN_PRESS  (press),
        .BTN_RELEASE(release_s),
        .BTN_LONG   (long_s),
        .PRESS_COUNT(count)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        cmpCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clearTally();
        edgeIdx        = 0;
        pressTally     = 0;
        releaseTally   = 0;
        longTally      = 0;
        overlapTally   = 0;
        firstLevelEdge = -1;
        pressEdge      = -1;
        longEdge       = -1;
        countAtLong    = -1;
    endtask

    // Advance one clock edge, then sample 1 ns later and tally the strobes.
    task automatic step();
        int cur;
        @(posedge clk);
        #1;
        cur = edgeIdx;
        edgeIdx++;
        if (level === 1'b1 && firstLevelEdge < 0) firstLevelEdge = cur;
        if (press === 1'b1) begin
            pressTally++;
            pressEdge = cur;
        end
        if (release_s === 1'b1) releaseTally++;
        if (long_s === 1'b1) begin
            longTally++;
            longEdge    = cur;
            countAtLong = int'(count);
        end
        if (long_s === 1'b1 && release_s === 1'b1) overlapTally++;
    endtask

    // Hold the pin at a value for a number of clock edges.
    task automatic applyStimulus(input logic value, input int cycles);
        btn = value;
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic doReset();
        rst = 1'b1;
        btn = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        clearTally();
    endtask

    initial begin
        cmpCount = 0;
        errCount = 0;
        rst      = 1'b1;
        btn      = 1'b1;
        clearTally();

        // Reset state with the pin idle.
        for (int i = 0; i < 3; i++) step();
        checkOutput("reset_level",   int'(level),     0);
        checkOutput("reset_press",   int'(press),     0);
        checkOutput("reset_release", int'(release_s), 0);
        checkOutput("reset_long",    int'(long_s),    0);
        checkOutput("reset_count",   int'(count),     0);
        rst = 1'b0;
        clearTally();

        // Clean press: pin goes low before edge 0 and stays low.
        applyStimulus(1'b0, 12);
        checkOutput("clean_first_level_edge", firstLevelEdge, 6);
        checkOutput("clean_press_edge",       pressEdge,      6);
        checkOutput("clean_press_strobes",    pressTally,     1);
        checkOutput("clean_level_held",       int'(level),    1);
        checkOutput("clean_press_ended",      int'(press),    0);
        checkOutput("clean_count",            int'(count),    0);

        // Reset mid-press, asserted between clock edges.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_level", int'(level), 0);
        step();
        step();
        rst = 1'b0;
        clearTally();
        applyStimulus(1'b0, 12);
        checkOutput("rearm_press_edge",    pressEdge,  6);
        checkOutput("rearm_press_strobes", pressTally, 1);

        // Bounce rejection.
        doReset();
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 20);
        checkOutput("bounce_level_seen", firstLevelEdge, -1);
        checkOutput("bounce_press",      pressTally,     0);
        checkOutput("bounce_release",    releaseTally,   0);
        checkOutput("bounce_long",       longTally,      0);

        // 33 short presses wrap the counter through 31 -> 0.
        doReset();
        for (int p = 0; p < 33; p++) begin
            applyStimulus(1'b0, 8);
            applyStimulus(1'b1, 8);
        end
        checkOutput("short_press_strobes",   pressTally,   33);
        checkOutput("short_release_strobes", releaseTally, 33);
        checkOutput("short_long_strobes",    longTally,    0);
        checkOutput("short_count_wrapped",   int'(count),  1);

        // Long press after one short press: counter clears on BTN_LONG and
        // the following release does not count.
        doReset();
        applyStimulus(1'b0, 8);
        applyStimulus(1'b1, 8);
        checkOutput("long_pre_count", int'(count), 1);
        clearTally();
        applyStimulus(1'b0, 40);
        applyStimulus(1'b1, 10);
        checkOutput("long_press_edge",    pressEdge,    6);
        checkOutput("long_strobes",       longTally,    1);
        checkOutput("long_edge",          longEdge,     25);
        checkOutput("long_count_at_long", countAtLong,  0);
        checkOutput("long_release",       releaseTally, 1);
        checkOutput("long_overlap",       overlapTally, 0);
        checkOutput("long_count_after",   int'(count),  0);

        // Long press with a 2-cycle release glitch: timing is not restarted.
        doReset();
        applyStimulus(1'b0, 12);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 26);
        applyStimulus(1'b1, 10);
        checkOutput("glitch_press_strobes",   pressTally,   1);
        checkOutput("glitch_long_strobes",    longTally,    1);
        checkOutput("glitch_long_edge",       longEdge,     25);
        checkOutput("glitch_release_strobes", releaseTally, 1);
        checkOutput("glitch_count",           int'(count),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
